// File: rtl/screen_sequencer.sv
// Screen-flow controller: selects start / game / game-over pixel source,
// sequences fades between them and gates the game logic.
module screen_sequencer #(
    parameter int unsigned FADE_FRAMES = 2,
    parameter int unsigned OVER_FRAMES = 120
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    input  logic        start_key,
    input  logic        game_over,
    input  logic [11:0] start_rgb,
    input  logic [11:0] game_rgb,
    input  logic [11:0] over_rgb,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic [2:0]  screen_state,
    output logic        game_enable,
    output logic        game_reset
);

    localparam int unsigned CNT_MAX = (OVER_FRAMES > FADE_FRAMES) ? OVER_FRAMES : FADE_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FADE_LAST = CNT_W'(FADE_FRAMES - 1);
    localparam logic [CNT_W-1:0] OVER_LAST = CNT_W'(OVER_FRAMES);

    typedef enum logic [2:0] {
        START    = 3'd0,
        FADE_OUT = 3'd1,
        FADE_IN  = 3'd2,
        PLAY     = 3'd3,
        OVER     = 3'd4
    } state_t;

    state_t           state, state_next;
    logic [4:0]       level, level_next;
    logic [CNT_W-1:0] frame_cnt, cnt_next;
    logic             key_req, key_next;
    logic             over_req, over_next;
    logic             game_reset_next;
    logic             key_prev;
    logic [9:0]       prev_x, prev_y;
    logic             frame_tick;
    logic             key_rise;
    logic [11:0]      src_rgb;

    assign frame_tick   = (DrawX == '0) && (DrawY == '0) && !((prev_x == '0) && (prev_y == '0));
    assign key_rise     = start_key && !key_prev;
    assign screen_state = state;
    assign game_enable  = (state == PLAY);

    // State, counters, request latches and input history registers
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state      <= START;
            level      <= 5'd16;
            frame_cnt  <= '0;
            key_req    <= 1'b0;
            over_req   <= 1'b0;
            key_prev   <= 1'b0;
            prev_x     <= '0;
            prev_y     <= '0;
            game_reset <= 1'b0;
        end else begin
            state      <= state_next;
            level      <= level_next;
            frame_cnt  <= cnt_next;
            key_req    <= key_next;
            over_req   <= over_next;
            key_prev   <= start_key;
            prev_x     <= DrawX;
            prev_y     <= DrawY;
            game_reset <= game_reset_next;
        end
    end

    // Next-state logic; every transition and level step happens on frame_tick only
    always_comb begin
        state_next      = state;
        level_next      = level;
        cnt_next        = frame_cnt;
        key_next        = key_req;
        over_next       = over_req | ((state == PLAY) && game_over);
        game_reset_next = 1'b0;
        if (frame_tick) begin
            // every tick either consumes or discards a pending press
            key_next = 1'b0;
            case (state)
                START: begin
                    level_next = 5'd16;
                    if (key_req) begin
                        state_next = FADE_OUT;
                        cnt_next   = '0;
                    end
                end
                FADE_OUT: begin
                    if (frame_cnt == FADE_LAST) begin
                        cnt_next   = '0;
                        level_next = level - 5'd1;
                        if (level == 5'd1) begin
                            state_next      = FADE_IN;
                            game_reset_next = 1'b1;
                        end
                    end else begin
                        cnt_next = frame_cnt + 1'b1;
                    end
                end
                FADE_IN: begin
                    if (frame_cnt == FADE_LAST) begin
                        cnt_next   = '0;
                        level_next = level + 5'd1;
                        if (level == 5'd15) begin
                            state_next = PLAY;
                        end
                    end else begin
                        cnt_next = frame_cnt + 1'b1;
                    end
                end
                PLAY: begin
                    if (over_req || game_over) begin
                        state_next = OVER;
                        cnt_next   = '0;
                        over_next  = 1'b0;
                    end
                end
                OVER: begin
                    if (key_req && (frame_cnt == OVER_LAST)) begin
                        state_next = START;
                        cnt_next   = '0;
                    end else if (frame_cnt != OVER_LAST) begin
                        cnt_next = frame_cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = START;
                    level_next = 5'd16;
                    cnt_next   = '0;
                end
            endcase
        end
        // a press landing on the tick edge itself is kept for the next frame
        key_next = key_next | key_rise;
    end

    // Source selection by current screen
    always_comb begin
        src_rgb = start_rgb;
        case (state)
            START, FADE_OUT: src_rgb = start_rgb;
            FADE_IN, PLAY:   src_rgb = game_rgb;
            OVER:            src_rgb = over_rgb;
            default:         src_rgb = start_rgb;
        endcase
    end

    function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] lv);
        logic [8:0] p;
        p = {5'b0, c} * {4'b0, lv};
        return 4'(p >> 4);
    endfunction

    // Registered brightness scaling and blanking of the selected source
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (!blank) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else begin
            red   <= scale(src_rgb[11:8], level);
            green <= scale(src_rgb[7:4], level);
            blue  <= scale(src_rgb[3:0], level);
        end
    end

endmodule

// File: tb/tb_screen_sequencer.sv
// Self-checking bench for screen_sequencer: vector table, directed flow
// sequences and randomized traffic against a frame-level reference model.
module tb_screen_sequencer;

    localparam int FF = 2;
    localparam int OF = 120;
    localparam int L  = 16;   // cycles per (shortened) frame

    logic        vga_clk;
    logic        reset;
    logic [9:0]  DrawX, DrawY;
    logic        blank, start_key, game_over;
    logic [11:0] start_rgb, game_rgb, over_rgb;
    logic [3:0]  red, green, blue;
    logic [2:0]  screen_state;
    logic        game_enable, game_reset;

    screen_sequencer #(.FADE_FRAMES(FF), .OVER_FRAMES(OF)) dut (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .start_key(start_key), .game_over(game_over),
        .start_rgb(start_rgb), .game_rgb(game_rgb), .over_rgb(over_rgb),
        .red(red), .green(green), .blue(blue), .screen_state(screen_state),
        .game_enable(game_enable), .game_reset(game_reset)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 25) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (frame-level view) ----------------
    int          m_state;     // screen number 0..4
    int          m_n;         // frame ticks spent in current screen
    bit          m_pend;      // key press waiting for a tick
    bit          m_over;      // game over reported during play
    bit          m_prev_key;
    bit          m_prev_zero;
    logic [11:0] exp_rgb;
    bit          exp_gr;
    int          tick_cnt;

    function automatic int level_of(input int s, input int n);
        if (s == 1) return 16 - n / FF;
        if (s == 2) return n / FF;
        return 16;
    endfunction

    function automatic logic [11:0] scale_rgb(input logic [11:0] c, input int lv);
        int r, g, b;
        r = int'(c[11:8]) * lv / 16;
        g = int'(c[7:4]) * lv / 16;
        b = int'(c[3:0]) * lv / 16;
        return {4'(r), 4'(g), 4'(b)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_n = 0; m_pend = 0; m_over = 0; m_prev_key = 0;
        m_prev_zero = 0; exp_rgb = '0; exp_gr = 0;
    endtask

    task automatic model_edge();
        bit tick, rise, at_zero;
        logic [11:0] src;
        at_zero = (DrawX == 0) && (DrawY == 0);
        tick = at_zero && !m_prev_zero;
        rise = start_key && !m_prev_key;
        src = (m_state <= 1) ? start_rgb : (m_state <= 3) ? game_rgb : over_rgb;
        exp_rgb = blank ? scale_rgb(src, level_of(m_state, m_n)) : 12'h000;
        exp_gr = 0;
        if (m_state == 3 && game_over) m_over = 1;
        if (tick) begin
            tick_cnt++;
            case (m_state)
                0: if (m_pend) begin m_state = 1; m_n = 0; end
                1: begin
                    m_n++;
                    if (m_n == 16 * FF) begin m_state = 2; m_n = 0; exp_gr = 1; end
                end
                2: begin
                    m_n++;
                    if (m_n == 16 * FF) begin m_state = 3; m_n = 0; end
                end
                3: if (m_over) begin m_state = 4; m_n = 0; m_over = 0; end
                default: begin
                    if (m_pend && m_n >= OF) begin m_state = 0; m_n = 0; end
                    else m_n++;
                end
            endcase
            m_pend = 0;
        end
        if (rise) m_pend = 1;
        m_prev_key = start_key;
        m_prev_zero = at_zero;
    endtask

    // ---------------- stepping ----------------
    int pos;
    int last_ss;
    int out_at, gr_at, play_at, over_at, start_at, gr_pulses;

    task automatic step();
        @(posedge vga_clk);
        if (reset) model_reset(); else model_edge();
        #1;
        chk("rgb", {red, green, blue}, exp_rgb);
        chk("screen_state", screen_state, m_state);
        chk("game_enable", game_enable, (m_state == 3));
        chk("game_reset", game_reset, exp_gr);
        if (game_reset === 1'b1) begin gr_pulses++; gr_at = tick_cnt; end
        if (int'(screen_state) != last_ss) begin
            case (screen_state)
                3'd0: start_at = tick_cnt;
                3'd1: out_at = tick_cnt;
                3'd3: play_at = tick_cnt;
                3'd4: over_at = tick_cnt;
                default: ;
            endcase
            last_ss = int'(screen_state);
        end
        pos = (pos + 1) % L;
        DrawX = 10'(pos);
        DrawY = '0;
    endtask

    task automatic rand_step();
        start_rgb = 12'($urandom);
        game_rgb  = 12'($urandom);
        over_rgb  = 12'($urandom);
        blank     = ($urandom % 8) != 0;
        step();
    endtask

    task automatic run_to_tick(input int t);
        int k = 0;
        while (tick_cnt < t && k < 400 * L) begin rand_step(); k++; end
    endtask

    task automatic goto_pos(input int p);
        int k = 0;
        while (pos != p && k < L) begin rand_step(); k++; end
    endtask

    task automatic wait_state(input int s, input int budget, input string nm);
        int k = 0;
        while (int'(screen_state) != s && k < budget) begin rand_step(); k++; end
        chk(nm, screen_state, s);
    endtask

    task automatic press_key(input int cycles);
        start_key = 1'b1;
        repeat (cycles) rand_step();
        start_key = 1'b0;
    endtask

    typedef struct {
        logic        blk;
        logic [11:0] rgb;
        logic [11:0] exp;
    } pix_vec_t;

    pix_vec_t vecs[7];

    initial begin
        int press_tick, gr_before;
        vecs[0] = '{1'b1, 12'hF84, 12'hF84};
        vecs[1] = '{1'b1, 12'hFFF, 12'hFFF};
        vecs[2] = '{1'b1, 12'h000, 12'h000};
        vecs[3] = '{1'b0, 12'hFFF, 12'h000};
        vecs[4] = '{1'b1, 12'h5A3, 12'h5A3};
        vecs[5] = '{1'b0, 12'h123, 12'h000};
        vecs[6] = '{1'b1, 12'h08F, 12'h08F};

        reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b1; start_key = 1'b0;
        game_over = 1'b0; start_rgb = 12'hF84; game_rgb = '0; over_rgb = '0;
        pos = 0; tick_cnt = 0; last_ss = 0; gr_pulses = 0;
        out_at = 0; gr_at = 0; play_at = 0; over_at = 0; start_at = 0;
        model_reset();

        repeat (3) step();
        chk("reset_rgb", {red, green, blue}, 12'h000);
        chk("reset_enable", game_enable, 1'b0);
        reset = 1'b0;

        // start screen at full brightness
        repeat (3 * L) step();
        chk("start_pixel_F84", {red, green, blue}, 12'hF84);
        chk("start_state", screen_state, 3'd0);

        foreach (vecs[i]) begin
            start_rgb = vecs[i].rgb;
            blank = vecs[i].blk;
            step();
            chk($sformatf("vec%0d", i), {red, green, blue}, vecs[i].exp);
        end

        // key press mid-frame starts the fade-out on the next tick
        goto_pos(5);
        press_tick = tick_cnt;
        press_key(5);
        wait_state(1, 3 * L, "reach_fade_out");
        chk("fade_out_entry_tick", out_at, press_tick + 1);

        run_to_tick(out_at + 2);
        start_rgb = 12'hFFF; blank = 1'b1; step();
        chk("level15_pixel", {red, green, blue}, 12'hEEE);
        run_to_tick(out_at + 16);
        start_rgb = 12'hFFF; blank = 1'b1; step();
        chk("level8_pixel", {red, green, blue}, 12'h777);

        wait_state(2, 40 * L, "reach_fade_in");
        chk("reset_pulse_frames", gr_at - out_at, 32);
        wait_state(3, 40 * L, "reach_play");
        chk("play_frames", play_at - gr_at, 32);
        chk("game_reset_pulses", gr_pulses, 1);

        // game over
        repeat (3 * L) rand_step();
        goto_pos(7);
        press_tick = tick_cnt;
        game_over = 1'b1; rand_step(); game_over = 1'b0;
        wait_state(4, 2 * L, "reach_over");
        chk("over_entry_tick", over_at, press_tick + 1);
        over_rgb = 12'hABC; blank = 1'b1; step();
        chk("over_pixel", {red, green, blue}, 12'hABC);

        // early key ignored, late key accepted
        run_to_tick(over_at + 10);
        goto_pos(6);
        press_key(3);
        repeat (2 * L) rand_step();
        chk("early_key_ignored", screen_state, 3'd4);
        run_to_tick(over_at + 121);
        goto_pos(6);
        press_tick = tick_cnt;
        press_key(3);
        wait_state(0, 2 * L, "reach_start");
        chk("start_entry_tick", start_at, press_tick + 1);

        start_rgb = 12'hFFF; game_rgb = 12'hFFF; over_rgb = 12'hFFF; blank = 1'b0;
        step();
        chk("blank_forces_zero", {red, green, blue}, 12'h000);

        // reset in the middle of the fade-in
        goto_pos(5);
        press_key(2);
        wait_state(2, 40 * L, "reach_fade_in2");
        begin
            int k = 0;
            while (!(m_state == 2 && m_n / FF == 5 && pos == 8) && k < 40 * L) begin
                rand_step(); k++;
            end
        end
        chk("at_level5", level_of(m_state, m_n), 5);
        gr_before = gr_pulses;
        start_rgb = 12'hFFF; game_rgb = 12'hFFF; blank = 1'b1;
        reset = 1'b1;
        #1;
        chk("async_rgb", {red, green, blue}, 12'h000);
        chk("async_state", screen_state, 3'd0);
        chk("async_enable", game_enable, 1'b0);
        chk("async_game_reset", game_reset, 1'b0);
        repeat (3) step();
        while (pos != 4) step();
        reset = 1'b0;
        repeat (3 * L) rand_step();
        chk("no_gr_after_reset", gr_pulses, gr_before);
        start_rgb = 12'hFFF; blank = 1'b1; step();
        chk("post_reset_full_level", {red, green, blue}, 12'hFFF);

        // randomized traffic
        for (int c = 0; c < 700 * L; c++) begin
            if ($urandom % 40 == 0) start_key = ~start_key;
            game_over = ($urandom % 300 == 0);
            rand_step();
        end
        game_over = 1'b0;
        start_key = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
- Top-level screen-flow controller for the game display.
- Decides each frame which full-screen pixel source drives the VGA outputs: start screen, game field or game-over screen.
- Sequences the transitions: start -> fade out -> fade in -> play -> over -> start.
- Gates the game logic through `game_enable` and `game_reset`, and applies brightness scaling plus blanking to the selected source.

Parameters:
- FADE_FRAMES, 2, frames per brightness step during fades (>=1)
- OVER_FRAMES, 120, minimum frames the game-over screen is held before a key is accepted (>=1)

Ports:
- vga_clk  input  1  pixel clock; all state on posedge
- reset  input  1  asynchronous, active-high reset
- DrawX  input  10  current pixel column, 0..799
- DrawY  input  10  current pixel row, 0..524
- blank  input  1  1 = visible region, colour allowed; 0 = force black
- start_key  input  1  level from keyboard decode; 1 while start key is held
- game_over  input  1  single-cycle pulse from game logic
- start_rgb  input  12  start-screen pixel {r,g,b}, already aligned to DrawX/DrawY
- game_rgb  input  12  game-field pixel {r,g,b}
- over_rgb  input  12  game-over-screen pixel {r,g,b}
- red  output  4  scaled red
- green  output  4  scaled green
- blue  output  4  scaled blue
- screen_state  output  3  encoded FSM state
- game_enable  output  1  1 only in PLAY
- game_reset  output  1  one-cycle pulse on entering FADE_IN

Behaviour:
- Reset, asynchronous:
  - state=START, level=16, frame counters=0, key latches cleared.
  - red/green/blue=0, screen_state=0, game_enable=0, game_reset=0.
- frame_tick:
  - One-cycle internal strobe, asserted when (DrawX,DrawY)==(0,0) and the previous cycle's coordinates were not (0,0).
  - Coordinates are registered for this comparison.
- Key edge detect:
  - start_key is registered.
  - A rising edge (prev 0, now 1) sets a sticky key_req flag.
  - key_req clears on the frame_tick that consumes it; a press-and-release within one frame is therefore not lost.
  - key_req also clears on every frame_tick outside START and OVER, so no stale presses carry over.
- All FSM transitions occur only on frame_tick; the source never switches mid-frame.
- States (screen_state encoding):
  - START (0): source=start, level=16. On tick with key_req -> FADE_OUT, frame_cnt=0.
  - FADE_OUT (1): source=start. On each tick frame_cnt increments; when frame_cnt==FADE_FRAMES-1, frame_cnt=0 and level-=1. On the tick where level reaches 0 -> FADE_IN; game_reset=1 for exactly that cycle.
  - FADE_IN (2): source=game. Level +=1 every FADE_FRAMES ticks. On the tick where level reaches 16 -> PLAY.
  - PLAY (3): source=game, level=16, game_enable=1. game_over pulse sets a sticky over_req; on the next tick -> OVER, frame_cnt=0.
  - OVER (4): source=over, level=16. frame_cnt counts ticks, saturating at OVER_FRAMES. key_req is honoured only when frame_cnt==OVER_FRAMES -> START; before that, key_req is cleared on each tick (ignored).
- Fade duration: 16*FADE_FRAMES frames each direction (defaults: 32 out + 32 in).
- game_over outside PLAY: ignored, over_req not set.
- game_over coinciding with the PLAY-exit tick: still taken; the same tick moves to OVER.
- Pixel datapath:
  - Registered, 1 cycle latency from the source inputs / blank to red/green/blue.
  - Each channel: out = (c * level) >> 4, with c 4 bits and level 5 bits (0..16), 9-bit product.
  - level=16 passes c unchanged; level=0 gives 0.
  - blank=0 forces 0 regardless of level.
- Outputs:
  - game_enable and screen_state are registered and follow state.
  - game_enable falls on the same edge that leaves PLAY.
- Reset mid-fade or mid-play: immediate return to START values; no residual game_reset pulse.

Test Plan:
- Reset, then 3 frames, start_rgb=0xF84, blank=1 -> red=F, green=8, blue=4 one cycle after the pixel; screen_state=0; game_enable=0.
- start_key 1 for 5 cycles mid-frame 1 -> FADE_OUT at frame-2 tick. Level 15 after 2 ticks, 8 after 16 ticks. With start_rgb=0xFFF at level 8 -> output 0x777.
- Continue the fade:
  - game_reset pulses exactly 1 cycle, 32 frames after FADE_OUT entry.
  - PLAY entered 32 frames later; game_enable=1 there and never earlier.
- In PLAY, game_over pulse at mid-frame -> next tick state=4, source=over_rgb, game_enable=0. A key at frame 10 of OVER is ignored (state stays 4); a key after frame 120 -> START on the following tick.
- blank=0 with level=16 and all sources 0xFFF -> red/green/blue=0.
- Assert reset asynchronously mid-FADE_IN (level=5) -> outputs 0 immediately; after release, state=START, level=16, game_reset never pulses.
